// File: rtl/unidade_busca.sv
// unidade_busca: MIPS fetch stage with PC, single-outstanding imem requests, 2-entry decode queue and redirect flush
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [5:0]  dec_opcode
);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, redir_pc;
  logic [1:0]  count_q, count_d, count_pop;
  logic [63:0] q_q [2];
  logic [63:0] q_d [2];
  logic        hs, pop, push;
  // outputs are masked during the reset cycle; queue head always sits in slot 0
  always_comb begin
    imem_req_valid = !reset && state_q == REQ && count_q != 2'd2;
    imem_req_addr  = fetch_pc_q;
    dec_valid      = !reset && count_q != 2'd0;
    dec_instr      = reset ? 32'd0 : q_q[0][63:32];
    dec_pc         = reset ? 32'd0 : q_q[0][31:0];
    dec_opcode     = dec_instr[31:26];
  end
  // next state: redirect overrides everything, stale in-flight responses are dropped
  always_comb begin
    hs         = imem_req_valid && imem_req_ready;
    pop        = dec_valid && dec_ready && !redirect_valid;
    push       = state_q == WAIT && imem_resp_valid && !redirect_valid;
    redir_pc   = redirect_pc & ~32'd3;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      state_d    = state_q == REQ ? (hs ? DROP : REQ) : (imem_resp_valid ? REQ : DROP);
    end else if (state_q == REQ) begin
      req_pc_d   = hs ? fetch_pc_q : req_pc_q;
      fetch_pc_d = hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
      state_d    = hs ? WAIT : REQ;
    end else if (imem_resp_valid) begin
      state_d = REQ;
    end
    count_pop = count_q - {1'b0, pop};
    q_d[0]    = push && count_pop == 2'd0 ? {imem_resp_data, req_pc_q} : (pop ? q_q[1] : q_q[0]);
    q_d[1]    = push && count_pop == 2'd1 ? {imem_resp_data, req_pc_q} : q_q[1];
    count_d   = redirect_valid ? 2'd0 : count_pop + {1'b0, push};
  end
  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      count_q    <= 2'd0;
      q_q[0]     <= 64'd0;
      q_q[1]     <= 64'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      q_q[0]     <= q_d[0];
      q_q[1]     <= q_d[1];
    end
  end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: table vectors, directed redirect sequences and random traffic against a stream-level fetch model
module tb_unidade_busca;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_ready = 1'b0, imem_resp_valid = 1'b0, redirect_valid = 1'b0, dec_ready = 1'b0;
  logic [31:0] imem_resp_data = 32'd0, redirect_pc = 32'd0;
  logic        imem_req_valid, dec_valid, req_valid1, dec_valid1;
  logic [31:0] imem_req_addr, dec_instr, dec_pc, addr1, instr1, pc1;
  logic [5:0]  dec_opcode, op1;

  unidade_busca u0 (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_opcode(dec_opcode)
  );
  unidade_busca #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clock(clock), .reset(reset),
    .imem_req_valid(req_valid1), .imem_req_ready(imem_req_ready), .imem_req_addr(addr1),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid1), .dec_ready(dec_ready), .dec_instr(instr1), .dec_pc(pc1), .dec_opcode(op1)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0, pops = 0, hs_cnt = 0;
  logic        mem_out = 1'b0, last_hs = 1'b0, chk_flush = 1'b0, hold_chk = 1'b0, redir_chk = 1'b0, prev_rd = 1'b0;
  logic [31:0] mem_addr = 32'd0, last_hs_addr = 32'd0, exp_pc = 32'd0, hold_addr = 32'd0, redir_addr = 32'd0;
  int          mem_cd = 0, lat_lo = 0, lat_hi = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h8C00_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock cycle: memory model drives, DUT outputs checked against the fetch-stream model
  task automatic step(input logic rst, input logic rdy, input logic drdy, input logic rd, input logic [31:0] rpc);
    logic rv, hs, pop;
    @(posedge clock);
    #1;
    rv = 1'b0;
    if (rst) mem_out = 1'b0;
    if (mem_out) begin
      if (mem_cd == 0) rv = 1'b1;
      else mem_cd--;
    end
    reset = rst; imem_req_ready = rdy; imem_resp_valid = rv;
    imem_resp_data = rv ? mem_word(mem_addr) : $urandom;
    dec_ready = drdy; redirect_valid = rd; redirect_pc = rpc;
    #3;
    if (rst) begin
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
      exp_pc = 32'd0; chk_flush = 1'b0; hold_chk = 1'b0; redir_chk = 1'b0; last_hs = 1'b0;
      return;
    end
    if (chk_flush) chk("flush_dec_valid", {63'd0, dec_valid}, 64'd0);
    if (hold_chk) chk("req_hold", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, hold_addr});
    if (redir_chk) chk("redir_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, redir_addr});
    if (dec_valid) begin
      chk("dec_pc", {32'd0, dec_pc}, {32'd0, exp_pc});
      chk("dec_instr", {32'd0, dec_instr}, {32'd0, mem_word(exp_pc)});
      chk("dec_opcode", {58'd0, dec_opcode}, {58'd0, dec_instr[31:26]});
    end
    hs = imem_req_valid && rdy;
    pop = dec_valid && drdy;
    if (hs) chk("one_outstanding", {63'd0, mem_out && !rv}, 64'd0);
    last_hs = hs; last_hs_addr = imem_req_addr;
    if (hs) hs_cnt++;
    if (rv) mem_out = 1'b0;
    if (hs) begin
      mem_out = 1'b1; mem_addr = imem_req_addr; mem_cd = $urandom_range(lat_hi, lat_lo);
    end
    hold_chk = imem_req_valid && !rdy && !rd; hold_addr = imem_req_addr;
    redir_chk = rd && !hs && !mem_out; redir_addr = {rpc[31:2], 2'b00};
    chk_flush = rd;
    if (rd) exp_pc = {rpc[31:2], 2'b00};
    else if (pop) begin exp_pc += 32'd4; pops++; end
  endtask

  typedef struct {
    logic rst, rdy, rv; logic [31:0] rdata;
    logic e_rv; logic [31:0] e_addr, e_addr1; logic e_dv; logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [31:0] got [3];
    int n, k;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0,          1'b0, 32'd0,  32'd0,          1'b0, 32'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 32'd0,  32'hFFFF_FFFC,  1'b0, 32'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h8C01_0000,  1'b0, 32'd0,  32'd0,          1'b0, 32'd0, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 32'd4,  32'd0,          1'b1, 32'd0, 32'h8C01_0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h2002_0005,  1'b0, 32'd0,  32'd0,          1'b0, 32'd0, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 32'd8,  32'd4,          1'b1, 32'd4, 32'h2002_0005};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020,  1'b0, 32'd0,  32'd0,          1'b0, 32'd0, 32'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 32'hC,  32'd8,          1'b1, 32'd8, 32'h0000_0020};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'd0,          1'b0, 32'd0,  32'd0,          1'b0, 32'd0, 32'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 32'd0,  32'hFFFF_FFFC,  1'b0, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      reset = tbl[i].rst; imem_req_ready = tbl[i].rdy; imem_resp_valid = tbl[i].rv;
      imem_resp_data = tbl[i].rdata; dec_ready = 1'b1; redirect_valid = 1'b0;
      #3;
      chk($sformatf("t%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, tbl[i].e_rv});
      chk($sformatf("t%0d_req_valid1", i), {63'd0, req_valid1}, {63'd0, tbl[i].e_rv});
      if (tbl[i].e_rv) begin
        chk($sformatf("t%0d_req_addr", i), {32'd0, imem_req_addr}, {32'd0, tbl[i].e_addr});
        chk($sformatf("t%0d_req_addr1", i), {32'd0, addr1}, {32'd0, tbl[i].e_addr1});
      end
      chk($sformatf("t%0d_dec_valid", i), {63'd0, dec_valid}, {63'd0, tbl[i].e_dv});
      if (tbl[i].e_dv || tbl[i].rst) begin
        chk($sformatf("t%0d_dec_pc", i), {32'd0, dec_pc}, {32'd0, tbl[i].e_pc});
        chk($sformatf("t%0d_dec_instr", i), {32'd0, dec_instr}, {32'd0, tbl[i].e_instr});
        chk($sformatf("t%0d_dec_opcode", i), {58'd0, dec_opcode}, {58'd0, tbl[i].e_instr[31:26]});
      end
    end
    // backpressure: only two requests accepted while decode stalls, then in-order drain
    lat_lo = 0; lat_hi = 0;
    step(1, 1, 0, 0, 0);
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    chk("bp_hs_count", 64'(hs_cnt), 64'd2);
    chk("bp_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("bp_head", {31'd0, dec_valid, dec_pc}, {31'd0, 1'b1, 32'd0});
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      logic v;
      logic [31:0] p;
      #0;
      v = dec_valid; p = dec_pc;
      step(0, 1, 1, 0, 0);
      if (dec_valid && k < 3) begin got[k] = dec_pc; k++; end
      if (v) begin end
      if (p == 32'd0) begin end
    end
    chk("bp_drain_n", 64'(k), 64'd3);
    chk("bp_pc0", {32'd0, got[0]}, 64'd0);
    chk("bp_pc1", {32'd0, got[1]}, 64'd4);
    chk("bp_pc2", {32'd0, got[2]}, 64'd8);
    // redirect while waiting: response dropped, fetch resumes at the target
    lat_lo = 1; lat_hi = 1;
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("w_first_hs", {31'd0, last_hs, last_hs_addr}, {31'd0, 1'b1, 32'd0});
    step(0, 1, 1, 1, 32'h40);
    n = 0;
    do begin step(0, 1, 1, 0, 0); n++; end while (!last_hs && n < 20);
    chk("w_next_req", {31'd0, last_hs, last_hs_addr}, {31'd0, 1'b1, 32'h40});
    n = 0;
    do begin step(0, 1, 1, 0, 0); n++; end while (!dec_valid && n < 20);
    chk("w_first_dec", {31'd0, dec_valid, dec_pc}, {31'd0, 1'b1, 32'h40});
    // redirect coinciding with a handshake: issued request becomes stale, low target bits forced to zero
    lat_lo = 0; lat_hi = 0;
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 32'h10);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 32'h103);
    chk("h_hs_at_10", {31'd0, last_hs, last_hs_addr}, {31'd0, 1'b1, 32'h10});
    step(0, 1, 1, 0, 0);
    chk("h_drop_req_valid", {63'd0, imem_req_valid}, 64'd0);
    n = 0;
    do begin step(0, 1, 1, 0, 0); n++; end while (!last_hs && n < 20);
    chk("h_next_req", {31'd0, last_hs, last_hs_addr}, {31'd0, 1'b1, 32'h100});
    n = 0;
    do begin step(0, 1, 1, 0, 0); n++; end while (!dec_valid && n < 20);
    chk("h_first_dec", {31'd0, dec_valid, dec_pc}, {31'd0, 1'b1, 32'h100});
    // redirect together with response and pop: nothing from the old path survives
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 32'h200);
    chk("f_pre_dec_valid", {63'd0, dec_valid}, 64'd1);
    step(0, 1, 1, 0, 0);
    chk("f_post_dec_valid", {63'd0, dec_valid}, 64'd0);
    n = 0;
    do begin step(0, 1, 1, 0, 0); n++; end while (!dec_valid && n < 20);
    chk("f_first_dec", {31'd0, dec_valid, dec_pc}, {31'd0, 1'b1, 32'h200});
    // random traffic against the stream model
    lat_lo = 0; lat_hi = 3;
    step(1, 1, 1, 0, 0);
    pops = 0; prev_rd = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic rd, rst;
      rst = ($urandom % 600) == 0;
      rd = !prev_rd && ($urandom % 25) == 0;
      prev_rd = rd;
      step(rst, ($urandom % 4) != 0, ($urandom % 3) != 0, rd, ($urandom % 2) ? $urandom : 32'hFFFF_FFF0 | $urandom_range(15, 0));
    end
    tests++;
    if (pops < 200) begin
      fails++;
      $display("FAIL rand_progress: got %0d pops expected at least 200", pops);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Instruction-fetch stage of the MIPS datapath; sits directly upstream of the control unit and decode.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with variable-latency response.
- Buffers fetched words in a 2-entry queue and presents {instr, pc, opcode} to decode over a valid/ready handshake.
- Handles branch/jump redirects from downstream: flushes the queue and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, word-aligned.
- imem_resp_valid  in  1  response data valid; one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; 1-cycle pulse.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced to 0).
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes head.
- dec_instr  out  32  instruction at queue head.
- dec_pc  out  32  address of dec_instr.
- dec_opcode  out  6  dec_instr[31:26]; drives control unit opcode.

Behaviour:
- Reset (sync, high): fetch_pc=RESET_PC, queue count=0, state=REQ. During the reset cycle imem_req_valid=0 and dec_valid=0; dec_instr, dec_pc and dec_opcode are 0.
- At most one outstanding (accepted, unanswered) request.
- FSM states: REQ, WAIT, DROP.
- REQ:
  - imem_req_valid=1 iff count<2; imem_req_addr=fetch_pc.
  - On req_valid&&req_ready: latch req_pc=fetch_pc, fetch_pc+=4 (32-bit wrap, 0xFFFFFFFC->0), count_reserved=1, go to WAIT.
  - Once asserted, req_valid/addr are held until accepted, except on redirect.
- WAIT:
  - imem_req_valid=0.
  - On resp_valid: push {resp_data, req_pc} to queue tail, go to REQ.
  - Space is guaranteed because a request is issued only when count+outstanding<=2.
- DROP:
  - imem_req_valid=0.
  - On resp_valid: discard data, go to REQ.
- Pop: dec_valid&&dec_ready removes the head. Push and pop in the same cycle keep count unchanged; FIFO order is preserved.
- Queue outputs come from registered storage. First instruction latency: accept at cycle N, response at N+k, dec_valid=1 at N+k+1.
- Redirect (highest priority, any state), same edge:
  - Queue flushed (count=0); dec_valid=0 next cycle. A pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - REQ, no handshake this cycle: pending request withdrawn; next cycle req_addr=new fetch_pc. This is the only allowed mid-request address change.
  - REQ with handshake this cycle: the request is issued, its response is stale, go to DROP.
  - WAIT without resp_valid: go to DROP.
  - WAIT with resp_valid: response discarded, go to REQ.
  - DROP: stay in DROP, still discard the one pending response.
- Reset mid-operation: all state cleared regardless of outstanding request. The memory must be reset by the same reset, so no orphan response is expected.
- dec_opcode is always dec_instr[31:26], valid only with dec_valid.

Test Plan:
- Reset, then imem_req_ready=1 and 1-cycle response latency, dec_ready=1 -> dec_pc sequence 0x0,0x4,0x8; dec_instr equals the memory words; dec_opcode=instr[31:26] (e.g. 0x8C...=lw -> 6'b100011).
- dec_ready=0 for 10 cycles -> exactly 2 requests accepted; dec_valid=1, head pc=0x0; no third request until a pop. Release -> pcs 0x0,0x4,0x8 in order.
- Redirect to 0x40 while in WAIT (response arrives 2 cycles later) -> that response is dropped; next req_addr=0x40; first post-redirect dec_pc=0x40.
- Redirect to 0x103 in the same cycle as a request handshake at 0x10 -> state DROP; next request addr=0x100; the 0x10 word never reaches decode.
- Redirect in the same cycle as resp_valid and dec_ready with 2 entries queued -> queue empty next cycle; no word from the old path is presented.
- RESET_PC=32'hFFFFFFFC -> first fetch at 0xFFFFFFFC, next at 0x00000000; assert reset mid-WAIT -> next cycle req_valid=0, dec_valid=0, then fetch restarts at RESET_PC.
